// File: rtl/imem_arbiter.sv
// Shares the single-port synchronous-read instruction memory between the CPU fetch
// stage and the host loader/debug port, holding the core in BOOT while code is loaded.
module imem_arbiter #(
    parameter int ADDR_W    = 14,
    parameter int HOST_MAX  = 4,
    parameter int BOOT_HOLD = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              boot_done,
    output logic              run,
    input  logic              f_req,
    input  logic [31:0]       f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [31:0]       f_rdata,
    input  logic              h_req,
    input  logic              h_we,
    input  logic [31:0]       h_addr,
    input  logic [31:0]       h_wdata,
    output logic              h_gnt,
    output logic              h_rvalid,
    output logic [31:0]       h_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam state_t     RESET_STATE = (BOOT_HOLD != 0) ? BOOT : RUN;
    localparam logic [3:0] STREAK_MAX  = 4'(HOST_MAX);

    state_t      state;
    state_t      state_next;
    logic [3:0]  streak;
    logic [3:0]  streak_next;
    logic        rd_valid;
    logic        rd_owner_h;

    // Byte-offset and above-range address bits are intentionally discarded (wraparound).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{f_addr[31:ADDR_W+2], f_addr[1:0],
                                h_addr[31:ADDR_W+2], h_addr[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RESET_STATE;
            streak     <= 4'd0;
            rd_valid   <= 1'b0;
            rd_owner_h <= 1'b0;
        end else begin
            state      <= state_next;
            streak     <= streak_next;
            rd_valid   <= mem_en & ~mem_we;
            rd_owner_h <= h_gnt;
        end
    end

    // Grants are suppressed while rst is high so nothing reaches memory mid-reset.
    always_comb begin
        f_gnt      = 1'b0;
        h_gnt      = 1'b0;
        state_next = state;
        if (!rst) begin
            case (state)
                BOOT: begin
                    h_gnt = h_req;
                    if (boot_done) begin
                        state_next = RUN;
                    end
                end
                RUN: begin
                    if (h_req && f_req) begin
                        if (streak == STREAK_MAX) begin
                            f_gnt = 1'b1;
                        end else begin
                            h_gnt = 1'b1;
                        end
                    end else begin
                        f_gnt = f_req;
                        h_gnt = h_req;
                    end
                end
                default: state_next = RESET_STATE;
            endcase
        end
    end

    always_comb begin
        streak_next = streak;
        if (!f_req || f_gnt) begin
            streak_next = 4'd0;
        end else if (h_gnt && streak != STREAK_MAX) begin
            streak_next = streak + 4'd1;
        end
    end

    assign run       = (state == RUN);
    assign mem_en    = f_gnt | h_gnt;
    assign mem_we    = h_gnt & h_we;
    assign mem_addr  = h_gnt ? h_addr[ADDR_W+1:2] : f_addr[ADDR_W+1:2];
    assign mem_wdata = h_wdata;

    assign f_rvalid  = rd_valid & ~rd_owner_h;
    assign h_rvalid  = rd_valid & rd_owner_h;
    assign f_rdata   = mem_rdata;
    assign h_rdata   = mem_rdata;

endmodule
